ram_arbiter: RTL
================

Name: ram_arbiter

Overview:
- Two-requester front end for the single-port `ram` block (write on clk edge when `st`=1; read data combinational on `O`).
- After reset, it sweeps the whole array to zero.
- It then shares the RAM between requester 0 and requester 1 with round-robin arbitration, valid/ready request handshakes and a registered read response.
- It sits between the CPU/DMA-style masters and the `ram` instance and owns all of that instance's `ad`/`st`/`X` inputs.

Parameters:
BUS_WIDTH, 8, data word width; must match the ram instance
ADDRESS_WIDTH, 8, address width; array depth is 2^ADDRESS_WIDTH

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has a request pending
req0_ready  output  1  requester 0 request accepted this cycle
req0_we  input  1  1 = write, 0 = read
req0_addr  input  ADDRESS_WIDTH  requester 0 address
req0_wdata  input  BUS_WIDTH  requester 0 write data
rsp0_valid  output  1  requester 0 read data valid (one-cycle pulse)
rsp0_rdata  output  BUS_WIDTH  requester 0 read data
req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata  same as requester 0, for requester 1
ram_ad  output  ADDRESS_WIDTH  to ram `ad`
ram_st  output  1  to ram `st`
ram_X  output  BUS_WIDTH  to ram `X`
ram_O  input  BUS_WIDTH  from ram `O`
busy  output  1  high while the init sweep runs

Behaviour:
- Reset (async, rst=1):
  - state=INIT, init counter=0, priority pointer=1 (requester 0 wins the first tie).
  - rsp0_valid=rsp1_valid=0; rsp0_rdata=rsp1_rdata=0; busy=1.
  - reqN_ready=0.
- INIT:
  - Each cycle drives ram_ad=counter, ram_st=1, ram_X=0, then increments the counter.
  - After the cycle with counter=2^ADDRESS_WIDTH-1, moves to RUN. The sweep takes exactly 2^ADDRESS_WIDTH cycles after rst deasserts.
  - busy=1 and reqN_ready=0 throughout; requests are held off, not dropped.
  - Counter is ADDRESS_WIDTH+1 bits so the terminal count does not wrap early.
- RUN, busy=0: combinational grant each cycle.
  - Only one valid: grant it.
  - Both valid: grant the requester opposite the pointer's last winner.
  - Neither valid: no grant.
  - Pointer updates to the granted index on every grant; unchanged when idle.
- reqN_ready = grantN; a transfer occurs when valid & ready. At most one transfer per cycle; throughput 1 per cycle.
- Granted request drives ram_ad=addr, ram_st=we, ram_X=wdata.
- No grant: ram_ad=0, ram_st=0, ram_X=0.
- Write: the ram updates on the same rising edge. No response is generated.
- Read: ram_O is sampled at the transfer edge. rspN_valid=1 for exactly the next cycle with rspN_rdata=sampled value. Read latency is 1 cycle from acceptance.
- rspN_rdata holds its last value when rspN_valid=0.
- Responses have no backpressure; requesters must accept them.
- Requesters must hold valid/we/addr/wdata stable until ready. Deasserting valid before ready is legal (request withdrawn).
- Read the cycle after a write to the same address (from either requester) returns the new data.
- Back-to-back grants alternate when both requesters stay valid: 0,1,0,1...
- A lone requester may be granted every cycle; no starvation when both compete.
- rst asserted mid-RUN or mid-INIT:
  - Immediately aborts, with no partial write after the reset edge.
  - Returns to INIT with counter=0.
  - Sweep restarts from address 0 after release.
  - Pending responses are lost.

Test Plan:
- ADDRESS_WIDTH=3: release rst → busy=1 for exactly 8 cycles, ram_st=1 with ram_ad 0..7 and ram_X=0, req0_ready=0 while req0_valid=1; then busy=0.
- After init, req0 write addr 5 data 0xA5, next cycle req0 read addr 5 → rsp0_valid pulses one cycle later with rsp0_rdata=0xA5; read of addr 6 returns 0x00.
- Both valid continuously after init (req0 reads addr 1, req1 reads addr 2) → ready alternates 0,1,0,1 starting with 0; rsp pulses alternate likewise with correct data.
- Only req1 valid for 4 cycles (writes 0x11..0x14 to addr 0..3) → req1_ready=1 all 4 cycles, req0_ready=0; subsequent reads return 0x11..0x14.
- Assert rst for one cycle mid-stream after writing 0x77 to addr 2 → all outputs return to reset values asynchronously; full sweep repeats; read addr 2 → 0x00.
- req0 raises valid and drops it before ready while req1 holds priority → no write to req0's address and no rsp0_valid.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-requester front end for a single-port RAM: zero-fill sweep after reset, then round-robin sharing.
// Latency: grant is combinational in the request cycle; read data returns one cycle after acceptance.
// Backpressure: reqN_ready drops while sweeping or while the other requester wins; responses cannot stall.
module ram_arbiter #(
  parameter int BUS_WIDTH     = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_we,
  input  logic [ADDRESS_WIDTH-1:0] req0_addr,
  input  logic [BUS_WIDTH-1:0]     req0_wdata,
  output logic                     rsp0_valid,
  output logic [BUS_WIDTH-1:0]     rsp0_rdata,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_we,
  input  logic [ADDRESS_WIDTH-1:0] req1_addr,
  input  logic [BUS_WIDTH-1:0]     req1_wdata,
  output logic                     rsp1_valid,
  output logic [BUS_WIDTH-1:0]     rsp1_rdata,
  output logic [ADDRESS_WIDTH-1:0] ram_ad,
  output logic                     ram_st,
  output logic [BUS_WIDTH-1:0]     ram_X,
  input  logic [BUS_WIDTH-1:0]     ram_O,
  output logic                     busy
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  // One extra counter bit keeps the last sweep address distinct from a wrap back to zero.
  localparam logic [ADDRESS_WIDTH:0] CNT_LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]             state_q, state_d;
  logic [ADDRESS_WIDTH:0] cnt_q, cnt_d;
  // Pointer holds the index of the last winner; the other requester wins a tie.
  logic                   ptr_q, ptr_d;
  logic                   rsp0_valid_q, rsp0_valid_d;
  logic                   rsp1_valid_q, rsp1_valid_d;
  logic [BUS_WIDTH-1:0]   rsp0_rdata_q, rsp0_rdata_d;
  logic [BUS_WIDTH-1:0]   rsp1_rdata_q, rsp1_rdata_d;
  logic                   grant0, grant1;

  // Sweep sequencing, round-robin grant and RAM port steering.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant0  = 1'b0;
    grant1  = 1'b0;
    ram_ad  = '0;
    ram_st  = 1'b0;
    ram_X   = '0;
    if (state_q == ST_INIT) begin
      ram_ad = cnt_q[ADDRESS_WIDTH-1:0];
      // Suppress the strobe while reset is held so nothing is written under reset.
      ram_st = ~rst;
      cnt_d  = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = ST_RUN;
      end
    end else begin
      grant0 = req0_valid & (~req1_valid | ptr_q);
      grant1 = req1_valid & (~req0_valid | ~ptr_q);
      if (grant0) begin
        ram_ad = req0_addr;
        ram_st = req0_we;
        ram_X  = req0_wdata;
        ptr_d  = 1'b0;
      end else if (grant1) begin
        ram_ad = req1_addr;
        ram_st = req1_we;
        ram_X  = req1_wdata;
        ptr_d  = 1'b1;
      end
    end
  end

  // Capture read data at the acceptance edge; data holds between pulses.
  always_comb begin
    rsp0_valid_d = grant0 & ~req0_we;
    rsp1_valid_d = grant1 & ~req1_we;
    rsp0_rdata_d = rsp0_valid_d ? ram_O : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? ram_O : rsp1_rdata_q;
  end

  // State registers; reset restarts the sweep and drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      ptr_q        <= 1'b1;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign busy       = (state_q == ST_INIT);

endmodule
